// File: rtl/ctrl_pkg.sv
// Shared types and constants for the ALU command sequencer.
package ctrl_pkg;

    localparam int unsigned DATA_W = 7;
    localparam int unsigned OP_W   = 3;

    localparam logic [OP_W-1:0] OP_NOT = 3'd0;
    localparam logic [OP_W-1:0] OP_ROR = 3'd1;
    localparam logic [OP_W-1:0] OP_NOP = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic              chain;
        logic [OP_W-1:0]   op;
        logic [DATA_W-1:0] b;
        logic [DATA_W-1:0] a;
    } cmd_t;

    localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; DEPTH must be a power of two, pointers wrap naturally.
module cmd_fifo #(
    parameter int unsigned WIDTH = 18,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read once counted valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Issues buffered commands one at a time to the combinational ALU and returns
// each captured result over a valid/ready response port with running counters.
module alu_op_sequencer
    import ctrl_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [OP_W-1:0]   cmd_op,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic              cmd_chain,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [OP_W-1:0]   alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_flag,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_flag,
    output logic              rsp_illegal,
    output logic              busy,
    output logic [CNT_W-1:0]  op_count,
    output logic [CNT_W-1:0]  flag_count
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [OP_W-1:0]   alu_op_q, alu_op_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
    logic              rsp_flag_q, rsp_flag_d;
    logic              rsp_illegal_q, rsp_illegal_d;
    logic [DATA_W-1:0] last_result_q, last_result_d;
    logic [CNT_W-1:0]  op_count_q, op_count_d;
    logic [CNT_W-1:0]  flag_count_q, flag_count_d;

    cmd_t fifo_wdata;
    cmd_t fifo_head;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_push;
    logic fifo_pop;

    assign fifo_wdata = '{chain: cmd_chain, op: cmd_op, b: cmd_b, a: cmd_a};
    assign fifo_push  = cmd_valid && !fifo_full;

    cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_op_d      = alu_op_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_result_d  = rsp_result_q;
        rsp_flag_d    = rsp_flag_q;
        rsp_illegal_d = rsp_illegal_q;
        last_result_d = last_result_q;
        op_count_d    = op_count_q;
        flag_count_d  = flag_count_q;
        fifo_pop      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    alu_a_d  = fifo_head.chain ? last_result_q : fifo_head.a;
                    alu_b_d  = fifo_head.b;
                    alu_op_d = fifo_head.op;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                rsp_result_d  = alu_result;
                rsp_flag_d    = alu_flag;
                rsp_illegal_d = (alu_op_q > OP_NOP);
                last_result_d = alu_result;
                rsp_valid_d   = 1'b1;
                state_d       = RESP;
            end
            RESP: begin
                // rsp_valid is always high here, so rsp_ready alone completes the handshake.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    op_count_d  = op_count_q + CNT_W'(1);
                    if (rsp_flag_q && (flag_count_q != '1)) flag_count_d = flag_count_q + CNT_W'(1);
                    alu_op_d = OP_NOP;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            alu_a_q       <= '0;
            alu_b_q       <= '0;
            alu_op_q      <= OP_NOP;
            rsp_valid_q   <= 1'b0;
            rsp_result_q  <= '0;
            rsp_flag_q    <= 1'b0;
            rsp_illegal_q <= 1'b0;
            last_result_q <= '0;
            op_count_q    <= '0;
            flag_count_q  <= '0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_op_q      <= alu_op_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flag_q    <= rsp_flag_d;
            rsp_illegal_q <= rsp_illegal_d;
            last_result_q <= last_result_d;
            op_count_q    <= op_count_d;
            flag_count_q  <= flag_count_d;
        end
    end

    assign cmd_ready   = !fifo_full;
    assign busy        = (state_q != IDLE) || !fifo_empty;
    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_op      = alu_op_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_result  = rsp_result_q;
    assign rsp_flag    = rsp_flag_q;
    assign rsp_illegal = rsp_illegal_q;
    assign op_count    = op_count_q;
    assign flag_count  = flag_count_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural 7-bit ALU attached.
module tb_alu_op_sequencer;

    logic       clk;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [2:0] cmd_op;
    logic [6:0] cmd_a;
    logic [6:0] cmd_b;
    logic       cmd_chain;
    logic [6:0] alu_a;
    logic [6:0] alu_b;
    logic [2:0] alu_op;
    logic [6:0] alu_result;
    logic       alu_flag;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [6:0] rsp_result;
    logic       rsp_flag;
    logic       rsp_illegal;
    logic       busy;
    logic [7:0] op_count;
    logic [7:0] flag_count;

    alu_op_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_a       (cmd_a),
        .cmd_b       (cmd_b),
        .cmd_chain   (cmd_chain),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_flag    (alu_flag),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_flag    (rsp_flag),
        .rsp_illegal (rsp_illegal),
        .busy        (busy),
        .op_count    (op_count),
        .flag_count  (flag_count)
    );

    // Downstream ALU: NOT, rotate-right by one, everything else yields zero.
    assign alu_result = (alu_op == 3'd0) ? ~alu_a :
                        (alu_op == 3'd1) ? {alu_a[0], alu_a[6:1]} : 7'h00;
    assign alu_flag   = |alu_result;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] res;
        logic       flag;
        logic       ill;
        logic [6:0] a;
        logic [2:0] op;
    } exp_t;

    exp_t exp_q[$];
    int   total  = 0;
    int   passed = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: compare each response at the sample point before its handshake edge.
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL unexpected_rsp: got result 0x%0h, expected no response", rsp_result);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rsp_result",  int'(rsp_result),  int'(e.res));
                chk("rsp_flag",    int'(rsp_flag),    int'(e.flag));
                chk("rsp_illegal", int'(rsp_illegal), int'(e.ill));
                chk("alu_a",       int'(alu_a),       int'(e.a));
                chk("alu_op",      int'(alu_op),      int'(e.op));
            end
        end
    end

    task automatic send(input logic chain, input logic [2:0] op, input logic [6:0] a,
                        input logic [6:0] b, input logic [6:0] res, input logic flag,
                        input logic [6:0] ea);
        exp_t e;
        int   n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_chain = chain;
        cmd_op    = op;
        cmd_a     = a;
        cmd_b     = b;
        while (!cmd_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!cmd_ready) begin
            total++;
            $display("FAIL send_timeout: got cmd_ready=0, expected 1");
        end else begin
            e.res  = res;
            e.flag = flag;
            e.ill  = (op > 3'd2);
            e.a    = ea;
            e.op   = op;
            exp_q.push_back(e);
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [6:0] bp_a   [6] = '{7'h00, 7'h7F, 7'h02, 7'h55, 7'h03, 7'h10};
    logic [2:0] bp_op  [6] = '{3'd0, 3'd0, 3'd1, 3'd2, 3'd1, 3'd0};
    logic [6:0] bp_res [6] = '{7'h7F, 7'h00, 7'h01, 7'h00, 7'h41, 7'h6F};
    logic       bp_flg [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    initial begin
        int accepted;
        exp_t e;
        rst_n     = 1'b0;
        cmd_valid = 1'b0;
        cmd_chain = 1'b0;
        cmd_op    = 3'd0;
        cmd_a     = 7'h00;
        cmd_b     = 7'h00;
        rsp_ready = 1'b0;
        #12;
        chk("rst_cmd_ready",  int'(cmd_ready),  1);
        chk("rst_rsp_valid",  int'(rsp_valid),  0);
        chk("rst_alu_op",     int'(alu_op),     2);
        chk("rst_busy",       int'(busy),       0);
        chk("rst_op_count",   int'(op_count),   0);
        chk("rst_flag_count", int'(flag_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // NOT with latency: accept, pop one edge later, response the edge after.
        rsp_ready = 1'b1;
        send(1'b0, 3'd0, 7'h0F, 7'h33, 7'h70, 1'b1, 7'h0F);
        chk("busy_after_accept", int'(busy), 1);
        @(posedge clk);
        #1;
        chk("not_alu_a_issued", int'(alu_a), 'h0F);
        chk("not_alu_b_issued", int'(alu_b), 'h33);
        chk("not_rsp_valid_early", int'(rsp_valid), 0);
        @(posedge clk);
        #1;
        chk("not_rsp_valid_lat", int'(rsp_valid), 1);
        drain();
        chk("not_alu_op_nop", int'(alu_op), 2);

        // Chained rotate uses the previous result as operand a.
        send(1'b0, 3'd1, 7'h01, 7'h00, 7'h40, 1'b1, 7'h01);
        send(1'b1, 3'd1, 7'h11, 7'h00, 7'h20, 1'b1, 7'h40);
        drain();

        // Backpressure: five accepted (one in flight + four buffered), sixth refused.
        rsp_ready = 1'b0;
        accepted  = 0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1;
            cmd_chain = 1'b0;
            cmd_op    = bp_op[i];
            cmd_a     = bp_a[i];
            cmd_b     = 7'h00;
            if (cmd_ready) begin
                e.res  = bp_res[i];
                e.flag = bp_flg[i];
                e.ill  = 1'b0;
                e.a    = bp_a[i];
                e.op   = bp_op[i];
                exp_q.push_back(e);
                accepted++;
            end
            @(posedge clk);
            #1;
        end
        cmd_valid = 1'b0;
        chk("bp_accepted",  accepted,          5);
        chk("bp_cmd_ready", int'(cmd_ready),   0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("bp_rsp_hold",   int'(rsp_result), 'h7F);
            chk("bp_valid_hold", int'(rsp_valid),  1);
        end
        rsp_ready = 1'b1;
        drain();
        chk("bp_op_count",   int'(op_count),   8);
        chk("bp_flag_count", int'(flag_count), 6);

        // Illegal opcode: issued unchanged, zero result, no flag increment.
        send(1'b0, 3'd5, 7'h7F, 7'h00, 7'h00, 1'b0, 7'h7F);
        drain();
        chk("ill_op_count",   int'(op_count),   9);
        chk("ill_flag_count", int'(flag_count), 6);

        // Reset while the first of two commands is executing.
        send(1'b0, 3'd0, 7'h0F, 7'h00, 7'h70, 1'b1, 7'h0F);
        send(1'b0, 3'd1, 7'h01, 7'h00, 7'h40, 1'b1, 7'h01);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        chk("mid_rst_rsp_valid", int'(rsp_valid), 0);
        chk("mid_rst_busy",      int'(busy),      0);
        chk("mid_rst_cmd_ready", int'(cmd_ready), 1);
        chk("mid_rst_alu_op",    int'(alu_op),    2);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("post_rst_busy",     int'(busy),      0);
        chk("post_rst_op_count", int'(op_count),  0);
        chk("post_rst_valid",    int'(rsp_valid), 0);

        // Recovery: a fresh command runs normally.
        send(1'b0, 3'd0, 7'h7F, 7'h00, 7'h00, 1'b0, 7'h7F);
        drain();
        chk("final_op_count",   int'(op_count),   1);
        chk("final_flag_count", int'(flag_count), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
